bitrev_read_stream: RTL and testbench

//  Drains a completed FFT frame from the spectrum buffer RAM and streams it out as
//  a valid/ready stream in natural bin order (bin 0..N-1). The frame sits in the RAM in
//  bit-reversed order, so each bin index is mapped to its bit-reversed RAM address.

---
 rtl/bitrev_read_stream.sv | 152 +++++++++++++++
 tb/tb_bitrev_read_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_read_stream.sv
// Streams one FFT frame out of the spectrum RAM in natural bin order, mapping each
// bin index to its bit-reversed RAM address and buffering returns in a 2-entry skid FIFO.
module bitrev_read_stream #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int BITREV = 1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int ENTRY_W = DATA_W + ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] i);
    logic [ADDR_W-1:0] r;
    r = i;
    if (BITREV != 0) begin
      for (int b = 0; b < ADDR_W; b++) r[b] = i[ADDR_W-1-b];
    end
    return r;
  endfunction

  state_t              state;
  state_t              state_nxt;

  logic [ADDR_W:0]     idx;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_p0;
  logic [2:0]          occ_p0;
  logic                issue_p0;
  logic                pop;

  logic                inflight_p1;
  logic                push_p1;
  logic [ADDR_W-1:0]   idx_p1;
  logic                last_p1;

  logic [ENTRY_W-1:0]  fifo_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          fifo_count;
  logic [ENTRY_W-1:0]  head;

  // Stage p0: read issue. Occupancy counts FIFO entries plus the read in flight,
  // minus the beat leaving this cycle, so the FIFO can never be overrun.
  always_comb begin
    pop      = out_valid & out_ready;
    occ_p0   = 3'(fifo_count) + 3'(inflight_p1) - 3'(pop);
    issue_p0 = (state == S_READ) && !idx[ADDR_W] && (occ_p0 < 3'd2);
    addr_p0  = map_addr(idx[ADDR_W-1:0]);
    ram_en   = issue_p0;
    ram_addr = issue_p0 ? addr_p0 : addr_q;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (issue_p0 && (&idx[ADDR_W-1:0])) state_nxt = S_DRAIN;
      S_DRAIN: if (!inflight_p1 && (fifo_count == 2'd0)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      idx         <= '0;
      addr_q      <= '0;
      inflight_p1 <= 1'b0;
    end else begin
      inflight_p1 <= issue_p0;
      if ((state == S_IDLE) && start) begin
        idx <= '0;
      end else if (issue_p0) begin
        idx <= idx + (ADDR_W+1)'(1);
      end
      if (issue_p0) addr_q <= addr_p0;
    end
  end

  // Stage p1: RAM data returns; tag it with the bin index captured at issue.
  always_ff @(posedge Clk) begin
    if (issue_p0) begin
      idx_p1  <= idx[ADDR_W-1:0];
      last_p1 <= &idx[ADDR_W-1:0];
    end
  end

  assign push_p1 = inflight_p1;

  always_ff @(posedge Clk) begin
    if (push_p1) fifo_mem[wr_ptr] <= {ram_dout, idx_p1, last_p1};
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push_p1) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_p1, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Stage p2: FIFO head drives the stream; fields read as zero when empty.
  always_comb begin
    head      = fifo_mem[rd_ptr];
    out_valid = (fifo_count != 2'd0);
    out_data  = out_valid ? head[ENTRY_W-1 -: DATA_W] : '0;
    out_index = out_valid ? head[ADDR_W:1] : '0;
    out_last  = out_valid & head[0];
  end

endmodule

// File: tb/tb_bitrev_read_stream.sv
// Bench for bitrev_read_stream: one bit-reversing and one pass-through instance share
// stimulus; a negedge scoreboard checks every accepted beat against RAM[a]=a.
`timescale 1ns/1ps
module tb_bitrev_read_stream;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int N  = 512;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic reset, start, out_ready;

  logic          busy_a, done_a, en_a, last_a, vld_a;
  logic [AW-1:0] addr_a, idx_a;
  logic [DW-1:0] dout_a, data_a;
  logic          busy_b, done_b, en_b, last_b, vld_b;
  logic [AW-1:0] addr_b, idx_b;
  logic [DW-1:0] dout_b, data_b;

  logic [DW-1:0] ram [N];

  bitrev_read_stream #(.ADDR_W(AW), .DATA_W(DW), .BITREV(1)) dut_a (
    .Clk(Clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
    .ram_en(en_a), .ram_addr(addr_a), .ram_dout(dout_a), .out_data(data_a),
    .out_index(idx_a), .out_last(last_a), .out_valid(vld_a), .out_ready(out_ready));

  bitrev_read_stream #(.ADDR_W(AW), .DATA_W(DW), .BITREV(0)) dut_b (
    .Clk(Clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
    .ram_en(en_b), .ram_addr(addr_b), .ram_dout(dout_b), .out_data(data_b),
    .out_index(idx_b), .out_last(last_b), .out_valid(vld_b), .out_ready(out_ready));

  // Registered-read RAM models, one per instance.
  always @(posedge Clk) if (en_a) dout_a <= ram[addr_a];
  always @(posedge Clk) if (en_b) dout_b <= ram[addr_b];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int brev9(input int v);
    int r;
    r = 0;
    for (int b = 0; b < AW; b++) if (v[b]) r = r | (1 << (AW - 1 - b));
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit mon_en = 1'b0;
  bit chk_timing = 1'b0;
  int exp_idx [2];
  int beats [2];
  int dones [2];
  int issued [2];
  int accepted [2];
  int fv [2];
  bit seen_v [2];
  bit stall [2];
  logic [DW+AW:0] prev [2];

  task automatic mon_one(input int i, input logic v, input logic [DW-1:0] d,
                         input logic [AW-1:0] ix, input logic l, input logic en,
                         input logic dn, input logic rdy);
    int expd;
    if (!mon_en) begin
      exp_idx[i] = 0; beats[i] = 0; dones[i] = 0; issued[i] = 0; accepted[i] = 0;
      fv[i] = 0; seen_v[i] = 1'b0; stall[i] = 1'b0;
      return;
    end
    if (v && stall[i]) chk($sformatf("stall_hold%0d", i), longint'({d, ix, l}), longint'(prev[i]));
    if (v && !seen_v[i]) begin
      seen_v[i] = 1'b1;
      fv[i] = cyc;
    end
    if (v && rdy) begin
      expd = (i == 0) ? brev9(exp_idx[i]) : exp_idx[i];
      chk($sformatf("beat_index%0d", i), ix, exp_idx[i]);
      chk($sformatf("beat_data%0d", i), d, expd);
      chk($sformatf("beat_last%0d", i), l, (exp_idx[i] == N - 1));
      exp_idx[i]++;
      beats[i]++;
      accepted[i]++;
    end
    if (en) issued[i]++;
    chk($sformatf("no_overflow%0d", i), (issued[i] - accepted[i]) <= 2, 1);
    if (dn) begin
      dones[i]++;
      chk($sformatf("frame_len%0d", i), beats[i], N);
      if (chk_timing) chk($sformatf("done_latency%0d", i), cyc - fv[i], 513);
      exp_idx[i] = 0;
      beats[i] = 0;
      seen_v[i] = 1'b0;
    end
    stall[i] = v && !rdy;
    prev[i] = {d, ix, l};
  endtask

  always @(negedge Clk) begin
    mon_one(0, vld_a, data_a, idx_a, last_a, en_a, done_a, out_ready);
    mon_one(1, vld_b, data_b, idx_b, last_b, en_b, done_b, out_ready);
  end

  typedef struct {
    logic start;
    logic rdy;
    logic busy;
    logic en;
    int   addr_a;
    int   addr_b;
    logic vld;
    int   idx;
    int   data_a;
    logic done;
  } vec_t;

  vec_t tab [10];

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_ram_en"}, en_a, 0);
    chk({tag, "_ram_addr"}, addr_a, 0);
    chk({tag, "_valid"}, vld_a, 0);
    chk({tag, "_data"}, data_a, 0);
    chk({tag, "_index"}, idx_a, 0);
    chk({tag, "_last"}, last_a, 0);
    chk({tag, "_busy_b"}, busy_b, 0);
    chk({tag, "_valid_b"}, vld_b, 0);
  endtask

  // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random
  task automatic run_frame(input int rmode, input int stall_n, input bit extra, input int nframes);
    int  budget;
    bit  p10, p300, restart;
    p10 = 1'b0; p300 = 1'b0; restart = 1'b0;
    budget = 2200 * nframes + stall_n;
    mon_en = 1'b0;
    chk_timing = (rmode == 0) && (stall_n == 0);
    @(negedge Clk); #1;
    mon_en = 1'b1;
    for (int ph = 0; ph < budget; ph++) begin
      @(posedge Clk); #1;
      start = (ph == 0);
      if (extra && !p10 && exp_idx[0] >= 10) begin start = 1'b1; p10 = 1'b1; end
      if (extra && !p300 && exp_idx[0] >= 300) begin start = 1'b1; p300 = 1'b1; end
      if (nframes > 1 && !restart && dones[0] == 1) begin start = 1'b1; restart = 1'b1; end
      case (rmode)
        1:       out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (ph < stall_n) out_ready = 1'b0;
      @(negedge Clk); #1;
      if (stall_n > 0 && ph == stall_n - 1) begin
        chk("stall_reads", issued[0], 2);
        chk("stall_valid", vld_a, 1);
        chk("stall_index", idx_a, 0);
      end
      if (dones[0] >= nframes && dones[1] >= nframes) break;
    end
    @(posedge Clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge Clk);
    #1;
    chk("dones_a", dones[0], nframes);
    chk("dones_b", dones[1], nframes);
    chk("beats_total_a", accepted[0], N * nframes);
    chk("beats_total_b", accepted[1], N * nframes);
    chk("idle_after_frame", busy_a, 0);
  endtask

  initial begin
    bit found;
    for (int a = 0; a < N; a++) ram[a] = DW'(a);
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;

    //           start rdy busy en addr_a addr_b vld idx data_a done
    tab[0] = '{1'b1, 1'b0, 1'b0, 1'b0,   0, 0, 1'b0, 0,   0, 1'b0};
    tab[1] = '{1'b0, 1'b0, 1'b1, 1'b1,   0, 0, 1'b0, 0,   0, 1'b0};
    tab[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 256, 1, 1'b0, 0,   0, 1'b0};
    tab[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 256, 1, 1'b1, 0,   0, 1'b0};
    tab[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 256, 1, 1'b1, 0,   0, 1'b0};
    tab[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 128, 2, 1'b1, 0,   0, 1'b0};
    tab[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 384, 3, 1'b1, 1, 256, 1'b0};
    tab[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 384, 3, 1'b1, 2, 128, 1'b0};
    tab[8] = '{1'b0, 1'b1, 1'b1, 1'b1,  64, 4, 1'b1, 2, 128, 1'b0};
    tab[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 320, 5, 1'b1, 3, 384, 1'b0};

    repeat (3) @(posedge Clk);
    #1 reset = 1'b0;
    @(negedge Clk); #1;
    chk_idle_zero("reset");

    for (int r = 0; r < 10; r++) begin
      @(posedge Clk); #1;
      start = tab[r].start;
      out_ready = tab[r].rdy;
      @(negedge Clk); #1;
      chk($sformatf("vec%0d_busy", r), busy_a, tab[r].busy);
      chk($sformatf("vec%0d_ram_en", r), en_a, tab[r].en);
      chk($sformatf("vec%0d_ram_addr", r), addr_a, tab[r].addr_a);
      chk($sformatf("vec%0d_valid", r), vld_a, tab[r].vld);
      chk($sformatf("vec%0d_index", r), idx_a, tab[r].idx);
      chk($sformatf("vec%0d_data", r), data_a, tab[r].data_a);
      chk($sformatf("vec%0d_done", r), done_a, tab[r].done);
      chk($sformatf("vec%0d_ram_en_b", r), en_b, tab[r].en);
      chk($sformatf("vec%0d_ram_addr_b", r), addr_b, tab[r].addr_b);
      chk($sformatf("vec%0d_index_b", r), idx_b, tab[r].idx);
      chk($sformatf("vec%0d_data_b", r), data_b, tab[r].idx);
    end

    @(posedge Clk); #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0;
    @(negedge Clk); #1;
    chk_idle_zero("abort_early");

    run_frame(0, 0, 1'b0, 1);
    run_frame(1, 0, 1'b0, 1);
    run_frame(2, 0, 1'b0, 1);
    run_frame(0, 100, 1'b0, 1);
    run_frame(0, 0, 1'b1, 1);

    // Abort at bin 200, then a fresh frame must come out whole.
    mon_en = 1'b0;
    chk_timing = 1'b0;
    @(negedge Clk); #1;
    mon_en = 1'b1;
    @(posedge Clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge Clk); #1;
      if (vld_a && idx_a == AW'(200)) found = 1'b1;
    end
    chk("reset_bin_reached", found, 1);
    @(posedge Clk); #1;
    reset = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0;
    @(negedge Clk); #1;
    chk_idle_zero("abort_bin200");
    repeat (30) @(negedge Clk);
    #1;
    chk("no_done_after_abort", dones[0] + dones[1], 0);
    run_frame(0, 0, 1'b0, 1);

    run_frame(0, 0, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
